crc16_frame_packer: RTL and testbench

- Upstream feeder for the 16-bit CRC16 engine (x^16+x^12+x^5+1, seed 16'hFFFF).
- Accepts 16-bit frame words on a valid/ready stream and forwards them to a registered output stream.
- Drives the engine's sop/din/din_vld/cap controls, then appends the captured CRC as the final word of each frame.
- Sits between the MC frame builder and the link serializer, in the same clk_sys domain as the CRC engine.

---
 rtl/crc16_frame_packer.sv | 158 +++++++++++++++
 tb/tb_crc16_frame_packer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_frame_packer.sv
// Frame packer feeding the CRC16 engine: forwards payload words through a
// registered valid/ready output and appends the engine's captured CRC word.
module crc16_frame_packer #(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic [15:0]      in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [15:0]      crc_din,
  output logic             crc_din_vld,
  output logic             crc_cap,
  output logic             crc_sop,
  input  logic [15:0]      crc_dout,
  output logic [15:0]      out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             err_len,
  output logic             err_sop,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC_OUT
  } state_t;

  localparam logic [CNT_W:0] MAX_CMP  = (CNT_W + 1)'(MAX_WORDS);
  localparam logic           ONE_WORD = (MAX_WORDS == 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_sop_q, out_sop_d;
  logic             out_eop_q, out_eop_d;
  logic             out_vld_q, out_vld_d;
  logic             err_len_q, err_len_d;
  logic             err_sop_q, err_sop_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic free;
  logic xfer;
  logic cnt_hit;

  assign crc_din   = in_data;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_vld   = out_vld_q;
  assign err_len   = err_len_q;
  assign err_sop   = err_sop_q;
  assign frame_cnt = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_vld_d   = out_vld_q;
    err_len_d   = 1'b0;
    err_sop_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    crc_din_vld = 1'b0;
    crc_cap     = 1'b0;
    crc_sop     = 1'b0;

    free    = !out_vld_q || out_rdy;
    in_rdy  = free && (state_q != CRC_OUT);
    xfer    = in_vld && in_rdy;
    cnt_hit = (({1'b0, cnt_q} + 1'b1) == MAX_CMP);

    // A free register with nothing to load empties; any load below re-validates it.
    if (free) out_vld_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer && in_sop) begin
          out_data_d  = in_data;
          out_sop_d   = 1'b1;
          out_eop_d   = 1'b0;
          out_vld_d   = 1'b1;
          cnt_d       = CNT_W'(1);
          crc_din_vld = 1'b1;
          if (in_eop || ONE_WORD) begin
            crc_cap   = 1'b1;
            err_len_d = ONE_WORD && !in_eop;
            state_d   = CRC_OUT;
          end else begin
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          out_data_d  = in_data;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
          out_vld_d   = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          crc_din_vld = 1'b1;
          err_sop_d   = in_sop;
          if (in_eop || cnt_hit) begin
            crc_cap   = 1'b1;
            err_len_d = cnt_hit && !in_eop;
            state_d   = CRC_OUT;
          end
        end
      end
      CRC_OUT: begin
        // Reseeding here never collides with a data word: in_rdy is low in this state.
        if (free) begin
          out_data_d = crc_dout;
          out_sop_d  = 1'b0;
          out_eop_d  = 1'b1;
          out_vld_d  = 1'b1;
          crc_sop    = 1'b1;
          cnt_d      = '0;
          if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_sop_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_vld_q   <= out_vld_d;
      err_len_q   <= err_len_d;
      err_sop_q   <= err_sop_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_crc16_frame_packer.sv
// Bench for crc16_frame_packer: CRC stub, directed scenarios and a randomized
// frame stream checked against a word-level frame model.
module tb_crc16_frame_packer;

  localparam int unsigned MAXW  = 4;
  localparam int unsigned CNTW  = 3;
  localparam logic [15:0] STUB_CRC = 16'hA5C3;

  logic            clk_sys = 1'b0;
  logic            rst_sys = 1'b1;
  logic [15:0]     in_data = '0;
  logic            in_sop = 1'b0, in_eop = 1'b0, in_vld = 1'b0;
  logic            in_rdy;
  logic [15:0]     crc_din;
  logic            crc_din_vld, crc_cap, crc_sop;
  logic [15:0]     crc_dout;
  logic [15:0]     out_data;
  logic            out_sop, out_eop, out_vld;
  logic            out_rdy = 1'b1;
  logic            err_len, err_sop;
  logic [CNTW-1:0] frame_cnt;

  int checks = 0;
  int failures = 0;
  bit rdy_rand = 1'b0;

  always #5 clk_sys = ~clk_sys;

  crc16_frame_packer #(.MAX_WORDS(MAXW), .CNT_W(CNTW)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_vld(in_vld), .in_rdy(in_rdy),
    .crc_din(crc_din), .crc_din_vld(crc_din_vld), .crc_cap(crc_cap), .crc_sop(crc_sop),
    .crc_dout(crc_dout),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_vld(out_vld), .out_rdy(out_rdy),
    .err_len(err_len), .err_sop(err_sop), .frame_cnt(frame_cnt)
  );

  // CRC engine stand-in: fixed CRC captured on crc_cap, cleared on reseed.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) crc_dout <= '0;
    else if (crc_cap) crc_dout <= STUB_CRC;
    else if (crc_sop) crc_dout <= '0;
  end

  // Monitor: everything observed is appended; tests compare from a base index.
  logic [17:0] out_q[$];
  logic [15:0] din_q[$];
  int cap_n = 0, sop_n = 0, elen_n = 0, esop_n = 0;

  always @(negedge clk_sys) begin
    if (!rst_sys) begin
      if (crc_din_vld) din_q.push_back(crc_din);
      if (crc_cap) cap_n++;
      if (crc_sop) sop_n++;
      if (out_vld && out_rdy) out_q.push_back({out_sop, out_eop, out_data});
      if (err_len) elen_n++;
      if (err_sop) esop_n++;
    end
  end

  // Word-level frame model: {sop, eop, data} entries.
  logic [17:0] exp_out[$];
  logic [15:0] exp_din[$];
  bit m_in = 1'b0;
  int m_cnt = 0, m_frames = 0, exp_caps = 0, exp_elen = 0, exp_esop = 0;

  function automatic logic [CNTW-1:0] exp_fcnt();
    int sat = (1 << CNTW) - 1;
    return CNTW'((m_frames > sat) ? sat : m_frames);
  endfunction

  task automatic model_clear();
    exp_out.delete();
    exp_din.delete();
    exp_caps = 0;
    exp_elen = 0;
    exp_esop = 0;
  endtask

  task automatic model_word(input logic [15:0] d, input logic s, input logic e);
    if (!m_in && !s) return;
    exp_out.push_back({(!m_in) ? 1'b1 : 1'b0, 1'b0, d});
    exp_din.push_back(d);
    if (m_in && s) exp_esop++;
    m_cnt = m_in ? m_cnt + 1 : 1;
    m_in = 1'b1;
    if (e || m_cnt == int'(MAXW)) begin
      exp_out.push_back({2'b01, STUB_CRC});
      exp_caps++;
      if (!e) exp_elen++;
      m_frames++;
      m_in = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (rdy_rand) out_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [15:0] d, input logic s, input logic e);
    bit got = 1'b0;
    in_data = d; in_sop = s; in_eop = e; in_vld = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk_sys);
      got = in_rdy;
      tick();
    end
    in_vld = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL send_accept data=%h got=in_rdy_low exp=accepted_within_64", d);
    end
    model_word(d, s, e);
  endtask

  task automatic drain(input int ob, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = ((out_q.size() - ob) >= exp_out.size());
    end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    checks++;
    if ({out_vld, out_sop, out_eop, err_len, err_sop, crc_sop, crc_cap, crc_din_vld} !== 8'h00) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=%b",
               {out_vld, out_sop, out_eop, err_len, err_sop, crc_sop, crc_cap, crc_din_vld}, 8'h00);
    end
    checks++;
    if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    checks++;
    if (frame_cnt !== '0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    checks++;
    if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
    tick();
    rst_sys = 1'b0;
    tick();
  endtask

  task automatic test_three_word();
    int ob = out_q.size(), db = din_q.size(), cb = cap_n, sb = sop_n;
    bit ok;
    rdy_rand = 1'b0; out_rdy = 1'b1;
    model_clear();
    send(16'h1111, 1'b1, 1'b0);
    send(16'h2222, 1'b0, 1'b0);
    send(16'h3333, 1'b0, 1'b1);
    drain(ob, ok);
    checks++;
    if (out_q.size() - ob != exp_out.size()) begin
      failures++; $display("FAIL three_out_len got=%0d exp=%0d", out_q.size() - ob, exp_out.size());
    end
    for (int i = 0; i < exp_out.size() && ob + i < out_q.size(); i++) begin
      checks++;
      if (out_q[ob + i] !== exp_out[i]) begin
        failures++; $display("FAIL three_out[%0d] got=%h exp=%h", i, out_q[ob + i], exp_out[i]);
      end
    end
    checks++;
    if (din_q.size() - db != 3) begin failures++; $display("FAIL three_din_vld got=%0d exp=3", din_q.size() - db); end
    for (int i = 0; i < exp_din.size() && db + i < din_q.size(); i++) begin
      checks++;
      if (din_q[db + i] !== exp_din[i]) begin
        failures++; $display("FAIL three_din[%0d] got=%h exp=%h", i, din_q[db + i], exp_din[i]);
      end
    end
    checks++;
    if (cap_n - cb != 1 || sop_n - sb != 1) begin
      failures++; $display("FAIL three_cap_sop got=%0d/%0d exp=1/1", cap_n - cb, sop_n - sb);
    end
    checks++;
    if (frame_cnt !== exp_fcnt()) begin failures++; $display("FAIL three_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fcnt()); end
  endtask

  task automatic test_single_word();
    rdy_rand = 1'b0; out_rdy = 1'b1;
    in_data = 16'hBEEF; in_sop = 1'b1; in_eop = 1'b1; in_vld = 1'b1;
    @(negedge clk_sys);
    checks++;
    if ({in_rdy, crc_din_vld, crc_cap, crc_sop} !== 4'b1110 || crc_din !== 16'hBEEF) begin
      failures++; $display("FAIL single_ctrl got=%b/%h exp=1110/beef", {in_rdy, crc_din_vld, crc_cap, crc_sop}, crc_din);
    end
    tick();
    in_vld = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({out_vld, out_sop, out_eop, out_data} !== {3'b110, 16'hBEEF}) begin
      failures++; $display("FAIL single_payload got=%h exp=%h", {out_vld, out_sop, out_eop, out_data}, {3'b110, 16'hBEEF});
    end
    checks++;
    if ({in_rdy, crc_sop} !== 2'b01) begin failures++; $display("FAIL single_crc_cycle got=%b exp=01", {in_rdy, crc_sop}); end
    tick();
    @(negedge clk_sys);
    checks++;
    if ({out_vld, out_sop, out_eop, out_data} !== {3'b101, STUB_CRC}) begin
      failures++; $display("FAIL single_crc_word got=%h exp=%h", {out_vld, out_sop, out_eop, out_data}, {3'b101, STUB_CRC});
    end
    checks++;
    if (in_rdy !== 1'b1) begin failures++; $display("FAIL single_rdy_back got=%b exp=1", in_rdy); end
    m_frames++;
    checks++;
    if (frame_cnt !== exp_fcnt()) begin failures++; $display("FAIL single_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fcnt()); end
    tick();
    @(negedge clk_sys);
    checks++;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL single_idle_vld got=%b exp=0", out_vld); end
    tick();
  endtask

  task automatic test_max_len();
    int ob = out_q.size(), eb = elen_n, sb = esop_n;
    bit ok;
    rdy_rand = 1'b0; out_rdy = 1'b1;
    model_clear();
    for (int i = 0; i < 6; i++) send(16'h4000 + 16'(i), (i == 0), 1'b0);
    drain(ob, ok);
    checks++;
    if (out_q.size() - ob != exp_out.size() || exp_out.size() != 5) begin
      failures++; $display("FAIL maxlen_out_len got=%0d exp=%0d", out_q.size() - ob, exp_out.size());
    end
    for (int i = 0; i < exp_out.size() && ob + i < out_q.size(); i++) begin
      checks++;
      if (out_q[ob + i] !== exp_out[i]) begin
        failures++; $display("FAIL maxlen_out[%0d] got=%h exp=%h", i, out_q[ob + i], exp_out[i]);
      end
    end
    checks++;
    if (elen_n - eb != exp_elen || esop_n - sb != 0) begin
      failures++; $display("FAIL maxlen_err got=%0d/%0d exp=%0d/0", elen_n - eb, esop_n - sb, exp_elen);
    end
    checks++;
    if (frame_cnt !== exp_fcnt()) begin failures++; $display("FAIL maxlen_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fcnt()); end
  endtask

  task automatic test_stall();
    int sb = sop_n;
    rdy_rand = 1'b0; out_rdy = 1'b1;
    in_data = 16'h00AA; in_sop = 1'b1; in_eop = 1'b1; in_vld = 1'b1;
    @(negedge clk_sys);
    tick();
    in_vld = 1'b0; out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      checks++;
      if ({out_vld, out_data, crc_sop, in_rdy} !== {1'b1, 16'h00AA, 2'b00}) begin
        failures++; $display("FAIL stall_payload[%0d] got=%h exp=%h", i, {out_vld, out_data, crc_sop, in_rdy}, {1'b1, 16'h00AA, 2'b00});
      end
      tick();
    end
    out_rdy = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (crc_sop !== 1'b1) begin failures++; $display("FAIL stall_accept_sop got=%b exp=1", crc_sop); end
    tick();
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      checks++;
      if ({out_vld, out_eop, out_data, crc_sop, in_rdy} !== {2'b11, STUB_CRC, 2'b00}) begin
        failures++; $display("FAIL stall_crc[%0d] got=%h exp=%h", i, {out_vld, out_eop, out_data, crc_sop, in_rdy}, {2'b11, STUB_CRC, 2'b00});
      end
      tick();
    end
    out_rdy = 1'b1;
    tick();
    @(negedge clk_sys);
    checks++;
    if (out_vld !== 1'b0 || sop_n - sb != 1) begin
      failures++; $display("FAIL stall_end got=%b/%0d exp=0/1", out_vld, sop_n - sb);
    end
    m_frames++;
    tick();
  endtask

  task automatic test_sop_mid();
    int ob = out_q.size(), sb = esop_n;
    bit ok;
    rdy_rand = 1'b0; out_rdy = 1'b1;
    model_clear();
    send(16'h0101, 1'b1, 1'b0);
    send(16'h0202, 1'b1, 1'b0);
    send(16'h0303, 1'b0, 1'b1);
    drain(ob, ok);
    checks++;
    if (out_q.size() - ob != exp_out.size()) begin
      failures++; $display("FAIL sopmid_out_len got=%0d exp=%0d", out_q.size() - ob, exp_out.size());
    end
    for (int i = 0; i < exp_out.size() && ob + i < out_q.size(); i++) begin
      checks++;
      if (out_q[ob + i] !== exp_out[i]) begin
        failures++; $display("FAIL sopmid_out[%0d] got=%h exp=%h", i, out_q[ob + i], exp_out[i]);
      end
    end
    checks++;
    if (esop_n - sb != exp_esop || exp_esop != 1) begin
      failures++; $display("FAIL sopmid_err_sop got=%0d exp=%0d", esop_n - sb, exp_esop);
    end
    checks++;
    if (frame_cnt !== exp_fcnt()) begin failures++; $display("FAIL sopmid_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fcnt()); end
  endtask

  task automatic test_mid_reset();
    int ob;
    bit ok;
    rdy_rand = 1'b0; out_rdy = 1'b1;
    model_clear();
    send(16'h0A0A, 1'b1, 1'b0);
    send(16'h0B0B, 1'b0, 1'b0);
    rst_sys = 1'b1;
    #1;
    checks++;
    if ({out_vld, in_rdy} !== 2'b01 || frame_cnt !== '0) begin
      failures++; $display("FAIL midrst_clear got=%b/%0d exp=01/0", {out_vld, in_rdy}, frame_cnt);
    end
    tick();
    rst_sys = 1'b0;
    m_in = 1'b0; m_frames = 0;
    model_clear();
    tick();
    ob = out_q.size();
    send(16'h0001, 1'b1, 1'b1);
    drain(ob, ok);
    checks++;
    if (out_q.size() - ob != 2) begin failures++; $display("FAIL midrst_out_len got=%0d exp=2", out_q.size() - ob); end
    for (int i = 0; i < exp_out.size() && ob + i < out_q.size(); i++) begin
      checks++;
      if (out_q[ob + i] !== exp_out[i]) begin
        failures++; $display("FAIL midrst_out[%0d] got=%h exp=%h", i, out_q[ob + i], exp_out[i]);
      end
    end
    checks++;
    if (frame_cnt !== exp_fcnt()) begin failures++; $display("FAIL midrst_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fcnt()); end
  endtask

  task automatic test_random();
    int ob = out_q.size(), db = din_q.size(), cb = cap_n, eb = elen_n, sb = esop_n;
    bit ok;
    model_clear();
    rdy_rand = 1'b1;
    for (int f = 0; f < 14; f++) begin
      int len = $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) send(16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < len; i++)
        send(16'($urandom), (i == 0) || ($urandom_range(0, 7) == 0),
             (i == len - 1) && ($urandom_range(0, 3) != 0));
    end
    send(16'hFFFF, 1'b0, 1'b1);
    drain(ob, ok);
    rdy_rand = 1'b0; out_rdy = 1'b1;
    checks++;
    if (out_q.size() - ob != exp_out.size()) begin
      failures++; $display("FAIL rand_out_len got=%0d exp=%0d", out_q.size() - ob, exp_out.size());
    end
    for (int i = 0; i < exp_out.size() && ob + i < out_q.size(); i++) begin
      checks++;
      if (out_q[ob + i] !== exp_out[i]) begin
        failures++; $display("FAIL rand_out[%0d] got=%h exp=%h", i, out_q[ob + i], exp_out[i]);
      end
    end
    checks++;
    if (din_q.size() - db != exp_din.size()) begin
      failures++; $display("FAIL rand_din_len got=%0d exp=%0d", din_q.size() - db, exp_din.size());
    end
    for (int i = 0; i < exp_din.size() && db + i < din_q.size(); i++) begin
      checks++;
      if (din_q[db + i] !== exp_din[i]) begin
        failures++; $display("FAIL rand_din[%0d] got=%h exp=%h", i, din_q[db + i], exp_din[i]);
      end
    end
    checks++;
    if (cap_n - cb != exp_caps || elen_n - eb != exp_elen || esop_n - sb != exp_esop) begin
      failures++; $display("FAIL rand_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                           cap_n - cb, elen_n - eb, esop_n - sb, exp_caps, exp_elen, exp_esop);
    end
    checks++;
    if (frame_cnt !== exp_fcnt()) begin failures++; $display("FAIL rand_frame_cnt got=%0d exp=%0d", frame_cnt, exp_fcnt()); end
  endtask

  initial begin
    test_reset();
    test_three_word();
    test_single_word();
    test_max_len();
    test_stall();
    test_sop_mid();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
